// File: rtl/mem_cycle_sequencer_pkg.sv
// Shared types for the memory cycle sequencer: FSM state encoding, read/write
// polarity constants and the registered control-output bundle.
package mem_cycle_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_F_MAR   = 4'd1,
        ST_F_MEM   = 4'd2,
        ST_F_IR    = 4'd3,
        ST_DECODE  = 4'd4,
        ST_LS_MAR  = 4'd5,
        ST_LS_MDR  = 4'd6,
        ST_LS_MEM  = 4'd7,
        ST_LS_DONE = 4'd8,
        ST_FAULT   = 4'd9
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // mdr_moc marks a memory-read window in which MDRLd follows MOC.
    typedef struct packed {
        logic mov;
        logic rw;
        logic ir_ld;
        logic mar_ld;
        logic mdr_ld;
        logic mdr_moc;
        logic mar_sel;
        logic mdr_sel;
        logic pc_inc;
        logic busy;
        logic fault;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        mov:     1'b0,
        rw:      RW_READ,
        ir_ld:   1'b0,
        mar_ld:  1'b0,
        mdr_ld:  1'b0,
        mdr_moc: 1'b0,
        mar_sel: 1'b0,
        mdr_sel: 1'b0,
        pc_inc:  1'b0,
        busy:    1'b0,
        fault:   1'b0
    };

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_F_MEM) || (s == ST_LS_MEM);
    endfunction

endpackage

// File: rtl/mem_cycle_sequencer_moc_timer.sv
// MOC wait counter: counts memory-cycle wait states and flags the last
// permitted one so the sequencer can abort to FAULT.
module moc_timer #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear outside memory cycles, saturate at the last wait slot.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A MOC arriving in the final slot drops en_i and therefore wins.
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_cycle_sequencer.sv
// Fetch/decode/load-store sequencer driving IR/MAR/MDR/FDR load enables,
// datapath mux selects and the MOV/MOC memory handshake.
module mem_cycle_sequencer
    import mem_cycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic run,
    input  logic MOC,
    input  logic ls_req,
    input  logic ls_store,
    input  logic set_flags,
    output logic MOV,
    output logic RW,
    output logic IRLd,
    output logic MARLd,
    output logic MDRLd,
    output logic FDRLd,
    output logic mar_sel,
    output logic mdr_sel,
    output logic pc_inc,
    output logic busy,
    output logic fault
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    logic   store_q;
    logic   store_d;
    logic   tmr_clr_s;
    logic   tmr_en_s;
    logic   expired_s;

    assign tmr_clr_s = !is_mem_state(state_q);
    assign tmr_en_s  = is_mem_state(state_q) && !MOC;

    moc_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_moc_timer (
        .clk_i     (CLK),
        .rst_ni    (RSTn),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .expired_o (expired_s)
    );

    // Next-state logic; the store/load choice is captured while in DECODE.
    always_comb begin
        state_d = state_q;
        store_d = store_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_F_MAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_F_MAR:  state_d = ST_F_MEM;
            ST_F_MEM: begin
                if (MOC) begin
                    state_d = ST_F_IR;
                end else if (expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_F_MEM;
                end
            end
            ST_F_IR:   state_d = ST_DECODE;
            ST_DECODE: begin
                store_d = ls_store;
                if (ls_req) begin
                    state_d = ST_LS_MAR;
                end else if (run) begin
                    state_d = ST_F_MAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LS_MAR: begin
                if (store_q) begin
                    state_d = ST_LS_MDR;
                end else begin
                    state_d = ST_LS_MEM;
                end
            end
            ST_LS_MDR: state_d = ST_LS_MEM;
            ST_LS_MEM: begin
                if (MOC) begin
                    state_d = ST_LS_DONE;
                end else if (expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_LS_MEM;
                end
            end
            ST_LS_DONE: begin
                if (run) begin
                    state_d = ST_F_MAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
    end

    // Output decode of the upcoming state so every control line is a flop.
    always_comb begin
        ctrl_d      = CTRL_RESET;
        ctrl_d.busy = (state_d != ST_IDLE);
        case (state_d)
            ST_F_MAR: begin
                ctrl_d.mar_ld  = 1'b1;
                ctrl_d.mar_sel = 1'b0;
            end
            ST_F_MEM: begin
                ctrl_d.mov     = 1'b1;
                ctrl_d.rw      = RW_READ;
                ctrl_d.mdr_moc = 1'b1;
                ctrl_d.mdr_sel = 1'b0;
            end
            ST_F_IR: begin
                ctrl_d.ir_ld  = 1'b1;
                ctrl_d.pc_inc = 1'b1;
            end
            ST_LS_MAR: begin
                ctrl_d.mar_ld  = 1'b1;
                ctrl_d.mar_sel = 1'b1;
            end
            ST_LS_MDR: begin
                ctrl_d.mdr_ld  = 1'b1;
                ctrl_d.mdr_sel = 1'b1;
            end
            ST_LS_MEM: begin
                ctrl_d.mov     = 1'b1;
                ctrl_d.rw      = store_d ? RW_WRITE : RW_READ;
                ctrl_d.mdr_moc = !store_d;
            end
            ST_FAULT: begin
                ctrl_d.fault = 1'b1;
            end
            default: begin
                ctrl_d.mov = 1'b0;
            end
        endcase
    end

    // State, latched store flag and control-output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            ctrl_q  <= CTRL_RESET;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Memory data and decoded flags are only valid alongside MOC / in DECODE,
    // so those two enables are qualified by their strobe inside a flopped window.
    assign MOV     = ctrl_q.mov;
    assign RW      = ctrl_q.rw;
    assign IRLd    = ctrl_q.ir_ld;
    assign MARLd   = ctrl_q.mar_ld;
    assign MDRLd   = ctrl_q.mdr_ld | (ctrl_q.mdr_moc & MOC);
    assign FDRLd   = (state_q == ST_DECODE) & set_flags;
    assign mar_sel = ctrl_q.mar_sel;
    assign mdr_sel = ctrl_q.mdr_sel;
    assign pc_inc  = ctrl_q.pc_inc;
    assign busy    = ctrl_q.busy;
    assign fault   = ctrl_q.fault;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Directed bench for mem_cycle_sequencer: a per-cycle vector table for the
// fetch/load/store/flags flows plus hand sequences for timeout and async reset.
module tb_mem_cycle_sequencer;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic run = 1'b0;
    logic MOC = 1'b0;
    logic ls_req = 1'b0;
    logic ls_store = 1'b0;
    logic set_flags = 1'b0;
    logic MOV, RW, IRLd, MARLd, MDRLd, FDRLd, mar_sel, mdr_sel, pc_inc, busy, fault;
    logic [10:0] dut_o;

    int total = 0;
    int bad = 0;

    // Bit order: MOV RW IRLd MARLd MDRLd FDRLd mar_sel mdr_sel pc_inc busy fault
    localparam logic [10:0] O_IDLE  = 11'b01000000000;
    localparam logic [10:0] O_BUSY  = 11'b01000000010;
    localparam logic [10:0] O_FMAR  = 11'b01010000010;
    localparam logic [10:0] O_FMEM  = 11'b11000000010;
    localparam logic [10:0] O_FMEMD = 11'b11001000010;
    localparam logic [10:0] O_FIR   = 11'b01100000110;
    localparam logic [10:0] O_DECF  = 11'b01000100010;
    localparam logic [10:0] O_LSMAR = 11'b01010010010;
    localparam logic [10:0] O_LSMDR = 11'b01001001010;
    localparam logic [10:0] O_LSMW  = 11'b10000000010;
    localparam logic [10:0] O_FAULT = 11'b01000000011;

    typedef struct {
        logic        run;
        logic        moc;
        logic        lsr;
        logic        lss;
        logic        sf;
        logic [10:0] exp;
    } vec_t;

    vec_t vq[$];

    mem_cycle_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .run(run), .MOC(MOC), .ls_req(ls_req),
        .ls_store(ls_store), .set_flags(set_flags), .MOV(MOV), .RW(RW),
        .IRLd(IRLd), .MARLd(MARLd), .MDRLd(MDRLd), .FDRLd(FDRLd),
        .mar_sel(mar_sel), .mdr_sel(mdr_sel), .pc_inc(pc_inc), .busy(busy),
        .fault(fault)
    );

    assign dut_o = {MOV, RW, IRLd, MARLd, MDRLd, FDRLd, mar_sel, mdr_sel, pc_inc, busy, fault};

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int idx, input logic [10:0] exp);
        total++;
        if (dut_o !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, dut_o, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic lr, input logic ls,
                       input logic sf, input logic [10:0] e);
        vec_t v;
        v.run = r; v.moc = m; v.lsr = lr; v.lss = ls; v.sf = sf; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        RSTn = 1'b0; run = 1'b0; MOC = 1'b0;
        ls_req = 1'b0; ls_store = 1'b0; set_flags = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int mov_cnt;
        int cyc;

        //   run moc lsr lss sf  expected
        add(1, 0, 0, 0, 0, O_IDLE);   // IDLE, run -> F_MAR
        add(1, 0, 0, 0, 0, O_FMAR);
        add(1, 0, 0, 0, 0, O_FMEM);
        add(1, 0, 0, 0, 0, O_FMEM);
        add(1, 1, 0, 0, 0, O_FMEMD);  // MOC two cycles after MOV
        add(1, 0, 0, 0, 0, O_FIR);
        add(1, 0, 0, 0, 0, O_BUSY);   // DECODE, no ls, no flags
        add(1, 0, 0, 0, 0, O_FMAR);
        add(1, 1, 0, 0, 0, O_FMEMD);
        add(1, 0, 0, 0, 0, O_FIR);
        add(1, 0, 1, 0, 1, O_DECF);   // DECODE: load + flags
        add(1, 0, 0, 1, 1, O_LSMAR);  // late ls_store/set_flags ignored
        add(1, 0, 0, 1, 0, O_FMEM);   // LS_MEM read waiting
        add(1, 1, 0, 0, 0, O_FMEMD);
        add(1, 1, 0, 0, 0, O_BUSY);   // LS_DONE, stray MOC ignored
        add(1, 1, 0, 0, 0, O_FMAR);
        add(1, 1, 0, 0, 0, O_FMEMD);
        add(1, 0, 0, 0, 0, O_FIR);
        add(1, 0, 1, 1, 0, O_BUSY);   // DECODE: store
        add(1, 0, 0, 0, 0, O_LSMAR);
        add(1, 0, 0, 0, 0, O_LSMDR);
        add(1, 0, 0, 0, 0, O_LSMW);
        add(1, 1, 0, 0, 0, O_LSMW);   // write completes, no MDRLd
        add(0, 0, 0, 0, 0, O_BUSY);   // LS_DONE, run low -> IDLE
        add(0, 0, 0, 0, 0, O_IDLE);
        add(1, 0, 0, 0, 0, O_IDLE);
        add(0, 0, 0, 0, 0, O_FMAR);   // run drops mid-instruction
        add(0, 1, 0, 0, 0, O_FMEMD);
        add(0, 0, 0, 0, 0, O_FIR);
        add(0, 0, 0, 0, 1, O_DECF);
        add(0, 0, 0, 0, 0, O_IDLE);

        @(negedge CLK);
        chk("reset", 0, O_IDLE);
        next_cycle();
        RSTn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            run = vq[i].run; MOC = vq[i].moc; ls_req = vq[i].lsr;
            ls_store = vq[i].lss; set_flags = vq[i].sf;
            @(negedge CLK);
            chk("vec", i, vq[i].exp);
            next_cycle();
        end

        // Timeout: MOC never arrives.
        do_reset();
        run = 1'b1;
        next_cycle();
        next_cycle();
        mov_cnt = 0;
        cyc = 0;
        while (fault == 1'b0 && cyc < 40) begin
            @(negedge CLK);
            if (MOV) mov_cnt++;
            next_cycle();
            cyc++;
        end
        chk_int("to_mov_cycles", mov_cnt, 15);
        @(negedge CLK);
        chk("to_fault", 0, O_FAULT);
        MOC = 1'b1; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge CLK);
            chk("to_sticky", i, O_FAULT);
        end

        // MOC on the 15th wait cycle completes normally.
        do_reset();
        run = 1'b1;
        next_cycle();
        next_cycle();
        repeat (14) next_cycle();
        MOC = 1'b1;
        @(negedge CLK);
        chk("moc15_mem", 0, O_FMEMD);
        next_cycle();
        MOC = 1'b0;
        @(negedge CLK);
        chk("moc15_ir", 0, O_FIR);

        // Async reset in the middle of a fetch memory cycle.
        do_reset();
        run = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        chk("ar_mem", 0, O_FMEM);
        #2 RSTn = 1'b0;
        #1 chk("ar_drop", 0, O_IDLE);
        run = 1'b0;
        MOC = 1'b1;
        next_cycle();
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("ar_idle", i, O_IDLE);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
